// File: rtl/calu_pkg.sv
// calu_pkg: shared definitions for the CALU add/subtract datapath.
//   calu_op_t   - two-bit operation code carried on in_op
//   FLAG_*      - bit positions inside the four-bit {N, Z, C, V} flag vector
//   op_carry_in - carry-in selection for each operation
package calu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ADC = 2'b10,
        OP_SBC = 2'b11
    } calu_op_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // SUB forms a - b as a + ~b + 1; the chaining ops take the external carry.
    function automatic logic op_carry_in(input calu_op_t op, input logic carry);
        logic cin;
        case (op)
            OP_ADD:  cin = 1'b0;
            OP_SUB:  cin = 1'b1;
            default: cin = carry;
        endcase
        return cin;
    endfunction

endpackage

// File: rtl/calu_addsub_pipe_cla_group.sv
// cla_group: one GROUP-bit carry-lookahead slice.
//   a, b  in   GROUP  operand bits (b already conditionally inverted)
//   cin   in   1      carry into the least significant bit of the group
//   sum   out  GROUP  sum bits
//   bg    out  1      block generate (group produces a carry regardless of cin)
//   bp    out  1      block propagate (group passes cin straight through)
module cla_group #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             cin,
    output logic [GROUP-1:0] sum,
    output logic             bg,
    output logic             bp
);

    logic [GROUP-1:0] gen;
    logic [GROUP-1:0] prop;
    logic [GROUP-1:0] carry;

    assign gen  = a & b;
    assign prop = a ^ b;
    assign sum  = prop ^ carry;
    assign bp   = &prop;

    // Bit carries and the block generate are both expanded from the same
    // generate/propagate terms; the block generate assumes a zero carry-in
    // so the caller can combine groups as bg | (bp & cin).
    always_comb begin
        logic acc;
        carry[0] = cin;
        for (int i = 1; i < GROUP; i++) begin
            carry[i] = gen[i-1] | (prop[i-1] & carry[i-1]);
        end
        acc = 1'b0;
        for (int i = 0; i < GROUP; i++) begin
            acc = gen[i] | (prop[i] & acc);
        end
        bg = acc;
    end

endmodule

// File: rtl/calu_addsub_pipe.sv
// calu_addsub_pipe: pipelined carry-lookahead adder/subtractor.
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid / in_ready  operand beat handshake
//   in_a, in_b           WIDTH-bit operands
//   in_op                ADD, SUB, ADC, SBC (calu_op_t)
//   in_carry             carry-in for ADC/SBC
//   sat                  signed saturate enable (only when CALU_SAT_EN is defined)
//   out_valid/out_ready  result handshake
//   out_result           WIDTH-bit sum or difference
//   out_flags            {N, Z, C, V}
// Optional feature macro: CALU_SAT_EN adds the sat port and signed clamping.
//
// Stage k adds groups k*GPS .. (k+1)*GPS-1. Only the inter-stage carry is a
// real pipeline quantity; operands and partial sums ride along with the beat.
// The last stage writes the result/flag registers directly, so the latency is
// exactly STAGES cycles. The whole pipe advances together (global stall).
module calu_addsub_pipe
    import calu_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic             in_carry,
`ifdef CALU_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags
);

    localparam int NGROUPS = WIDTH / GROUP;
    localparam int GPS     = NGROUPS / STAGES;
    localparam int SBITS   = GPS * GROUP;

    logic advance;

    // A full output register that is not being drained freezes every stage.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : stg
        logic [WIDTH-1:0] a_i;
        logic [WIDTH-1:0] b_i;
        logic [WIDTH-1:0] sum_i;
        logic [WIDTH-1:0] sum_o;
        logic             c_i;
        logic             v_i;
`ifdef CALU_SAT_EN
        logic             sat_i;
`endif
        logic [GPS:0]     gc;
        logic [GPS-1:0]   bg;
        logic [GPS-1:0]   bp;
        logic [SBITS-1:0] slice_sum;

        if (k == 0) begin : g_src
            assign a_i   = in_a;
            assign b_i   = in_b ^ {WIDTH{in_op[0]}};
            assign sum_i = '0;
            assign c_i   = op_carry_in(calu_op_t'(in_op), in_carry);
            assign v_i   = in_valid;
`ifdef CALU_SAT_EN
            assign sat_i = sat;
`endif
        end else begin : g_src
            assign a_i   = stg[k-1].g_reg.q_a;
            assign b_i   = stg[k-1].g_reg.q_b;
            assign sum_i = stg[k-1].g_reg.q_sum;
            assign c_i   = stg[k-1].g_reg.q_c;
            assign v_i   = stg[k-1].g_reg.q_v;
`ifdef CALU_SAT_EN
            assign sat_i = stg[k-1].g_reg.q_sat;
`endif
        end

        assign gc[0] = c_i;

        for (genvar j = 0; j < GPS; j++) begin : grp
            localparam int LSB = (k * GPS + j) * GROUP;

            cla_group #(
                .GROUP (GROUP)
            ) u_cla (
                .a   (a_i[LSB +: GROUP]),
                .b   (b_i[LSB +: GROUP]),
                .cin (gc[j]),
                .sum (slice_sum[j*GROUP +: GROUP]),
                .bg  (bg[j]),
                .bp  (bp[j])
            );

            assign gc[j+1] = bg[j] | (bp[j] & gc[j]);
        end

        // Splice this stage's slice into the partial sum carried by the beat.
        always_comb begin
            sum_o = sum_i;
            sum_o[k*SBITS +: SBITS] = slice_sum;
        end

        if (k < STAGES - 1) begin : g_reg
            logic [WIDTH-1:0] q_a;
            logic [WIDTH-1:0] q_b;
            logic [WIDTH-1:0] q_sum;
            logic             q_c;
            logic             q_v;
`ifdef CALU_SAT_EN
            logic             q_sat;
`endif

            // Bubbles move as valid=0; their data is never loaded.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    q_v <= 1'b0;
                end else if (advance) begin
                    q_v <= v_i;
                    if (v_i) begin
                        q_a   <= a_i;
                        q_b   <= b_i;
                        q_sum <= sum_o;
                        q_c   <= gc[GPS];
`ifdef CALU_SAT_EN
                        q_sat <= sat_i;
`endif
                    end
                end
            end
        end else begin : g_out
            logic [WIDTH-1:0] res;
            logic [3:0]       flags;
            logic             ovf;

            assign ovf = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum_o[WIDTH-1] != a_i[WIDTH-1]);

            // Clamp toward the sign of a; V keeps reporting the raw overflow.
            always_comb begin
                res = sum_o;
`ifdef CALU_SAT_EN
                if (sat_i && ovf) begin
                    res = a_i[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
                end
`endif
            end

            always_comb begin
                flags         = '0;
                flags[FLAG_N] = res[WIDTH-1];
                flags[FLAG_Z] = (res == '0);
                flags[FLAG_C] = gc[GPS];
                flags[FLAG_V] = ovf;
            end

            // Result registers hold their last value across bubbles and stalls.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    out_valid  <= 1'b0;
                    out_result <= '0;
                    out_flags  <= '0;
                end else if (advance) begin
                    out_valid <= v_i;
                    if (v_i) begin
                        out_result <= res;
                        out_flags  <= flags;
                    end
                end
            end
        end
    end

endmodule
